// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control through the EX/MEM/WB registers, inserts bubbles on stall/flush,
// and reports load-use hazards back to the decoder. Optional counters under `CTRL_PIPE_STATS_EN`.
module ctrl_pipe #(
  parameter int RW     = 5,
  parameter int ALUC_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              d_valid,
  input  logic              d_wreg,
  input  logic              d_mem2reg,
  input  logic              d_wmem,
  input  logic [ALUC_W-1:0] d_aluc,
  input  logic              d_aluimm,
  input  logic              d_shift,
  input  logic              d_jal,
  input  logic [RW-1:0]     d_rn,
  input  logic [RW-1:0]     d_rs,
  input  logic [RW-1:0]     d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic              stall,
  input  logic              flush,
  output logic              e_wreg,
  output logic              e_m2reg,
  output logic              e_wmem,
  output logic              e_aluimm,
  output logic              e_shift,
  output logic              e_jal,
  output logic [ALUC_W-1:0] e_aluc,
  output logic [RW-1:0]     e_rn,
  output logic              m_wreg,
  output logic              m_m2reg,
  output logic              m_wmem,
  output logic [RW-1:0]     m_rn,
  output logic              w_wreg,
  output logic              w_m2reg,
  output logic [RW-1:0]     w_rn,
  output logic              e_valid,
  output logic              m_valid,
  output logic              w_valid,
  output logic              load_use
`ifdef CTRL_PIPE_STATS_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       retire_cnt
`endif
);

  logic bubble;
  assign bubble = stall | flush;

  // NOTE: sequential state uses non-blocking assignments so every stage samples the
  // previous-cycle value of the stage before it, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      e_valid  <= 1'b0;
      e_wreg   <= 1'b0;
      e_m2reg  <= 1'b0;
      e_wmem   <= 1'b0;
      e_aluimm <= 1'b0;
      e_shift  <= 1'b0;
      e_jal    <= 1'b0;
      e_aluc   <= '0;
      e_rn     <= '0;
      m_valid  <= 1'b0;
      m_wreg   <= 1'b0;
      m_m2reg  <= 1'b0;
      m_wmem   <= 1'b0;
      m_rn     <= '0;
      w_valid  <= 1'b0;
      w_wreg   <= 1'b0;
      w_m2reg  <= 1'b0;
      w_rn     <= '0;
    end else begin
      if (bubble) begin
        e_valid  <= 1'b0;
        e_wreg   <= 1'b0;
        e_m2reg  <= 1'b0;
        e_wmem   <= 1'b0;
        e_aluimm <= 1'b0;
        e_shift  <= 1'b0;
        e_jal    <= 1'b0;
        e_aluc   <= '0;
        e_rn     <= '0;
      end else begin
        // Writes to r0 and side effects of non-instructions are killed at capture.
        e_valid  <= d_valid;
        e_wreg   <= d_wreg & d_valid & (d_rn != '0);
        e_m2reg  <= d_mem2reg;
        e_wmem   <= d_wmem & d_valid;
        e_aluimm <= d_aluimm;
        e_shift  <= d_shift;
        e_jal    <= d_jal;
        e_aluc   <= d_aluc;
        e_rn     <= d_rn;
      end
      m_valid <= e_valid;
      m_wreg  <= e_wreg;
      m_m2reg <= e_m2reg;
      m_wmem  <= e_wmem;
      m_rn    <= e_rn;
      w_valid <= m_valid;
      w_wreg  <= m_wreg;
      w_m2reg <= m_m2reg;
      w_rn    <= m_rn;
    end
  end

  assign load_use = e_valid & e_m2reg & e_wreg &
                    ((d_use_rs & (d_rs == e_rn)) | (d_use_rt & (d_rt == e_rn)));

`ifdef CTRL_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bubble_cnt <= '0;
      retire_cnt <= '0;
    end else begin
      if (bubble)  bubble_cnt <= bubble_cnt + 32'd1;
      if (w_valid) retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus randomized traffic against a
// delay-line reference model of retired instruction bundles.
module tb_ctrl_pipe;

  localparam int RW     = 5;
  localparam int ALUC_W = 4;

  typedef struct {
    logic              valid;
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              aluimm;
    logic              shift;
    logic              jal;
    logic [ALUC_W-1:0] aluc;
    logic [RW-1:0]     rn;
  } bundle_t;

  logic clk = 1'b0;
  logic resetn;
  logic d_valid, d_wreg, d_mem2reg, d_wmem, d_aluimm, d_shift, d_jal;
  logic [ALUC_W-1:0] d_aluc;
  logic [RW-1:0] d_rn, d_rs, d_rt;
  logic d_use_rs, d_use_rt, stall, flush;
  logic e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_jal;
  logic [ALUC_W-1:0] e_aluc;
  logic [RW-1:0] e_rn, m_rn, w_rn;
  logic m_wreg, m_m2reg, m_wmem, w_wreg, w_m2reg;
  logic e_valid, m_valid, w_valid, load_use;
`ifdef CTRL_PIPE_STATS_EN
  logic [31:0] bubble_cnt, retire_cnt;
  logic [31:0] exp_bubble, exp_retire;
`endif

  int checks = 0;
  int passed = 0;
  bundle_t q[$];

  always #5 clk = ~clk;

  ctrl_pipe #(.RW(RW), .ALUC_W(ALUC_W)) dut (
    .clk(clk), .resetn(resetn),
    .d_valid(d_valid), .d_wreg(d_wreg), .d_mem2reg(d_mem2reg), .d_wmem(d_wmem),
    .d_aluc(d_aluc), .d_aluimm(d_aluimm), .d_shift(d_shift), .d_jal(d_jal),
    .d_rn(d_rn), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .stall(stall), .flush(flush),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_aluimm(e_aluimm),
    .e_shift(e_shift), .e_jal(e_jal), .e_aluc(e_aluc), .e_rn(e_rn),
    .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_wmem(m_wmem), .m_rn(m_rn),
    .w_wreg(w_wreg), .w_m2reg(w_m2reg), .w_rn(w_rn),
    .e_valid(e_valid), .m_valid(m_valid), .w_valid(w_valid), .load_use(load_use)
`ifdef CTRL_PIPE_STATS_EN
    , .bubble_cnt(bubble_cnt), .retire_cnt(retire_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bundle_t nop_b();
    bundle_t b;
    b.valid = 0; b.wreg = 0; b.m2reg = 0; b.wmem = 0;
    b.aluimm = 0; b.shift = 0; b.jal = 0; b.aluc = '0; b.rn = '0;
    return b;
  endfunction

  // An instruction that reaches EX: writes to r0 and effects of invalid slots vanish.
  function automatic bundle_t issued_b();
    bundle_t b;
    b.valid  = d_valid;
    b.wreg   = d_wreg && d_valid && (d_rn != 0);
    b.m2reg  = d_mem2reg;
    b.wmem   = d_wmem && d_valid;
    b.aluimm = d_aluimm;
    b.shift  = d_shift;
    b.jal    = d_jal;
    b.aluc   = d_aluc;
    b.rn     = d_rn;
    return b;
  endfunction

  task automatic model_reset();
    q = {nop_b(), nop_b(), nop_b()};
`ifdef CTRL_PIPE_STATS_EN
    exp_bubble = '0;
    exp_retire = '0;
`endif
  endtask

  task automatic compare_all();
    bundle_t e, m, w;
    logic lu;
    e = q[0]; m = q[1]; w = q[2];
    lu = e.valid && e.m2reg && e.wreg &&
         ((d_use_rs && d_rs == e.rn) || (d_use_rt && d_rt == e.rn));
    check("e_valid", e_valid, e.valid);
    check("e_wreg", e_wreg, e.wreg);
    check("e_m2reg", e_m2reg, e.m2reg);
    check("e_wmem", e_wmem, e.wmem);
    check("e_aluimm", e_aluimm, e.aluimm);
    check("e_shift", e_shift, e.shift);
    check("e_jal", e_jal, e.jal);
    check("e_aluc", e_aluc, e.aluc);
    check("e_rn", e_rn, e.rn);
    check("m_valid", m_valid, m.valid);
    check("m_wreg", m_wreg, m.wreg);
    check("m_m2reg", m_m2reg, m.m2reg);
    check("m_wmem", m_wmem, m.wmem);
    check("m_rn", m_rn, m.rn);
    check("w_valid", w_valid, w.valid);
    check("w_wreg", w_wreg, w.wreg);
    check("w_m2reg", w_m2reg, w.m2reg);
    check("w_rn", w_rn, w.rn);
    check("load_use", load_use, lu);
`ifdef CTRL_PIPE_STATS_EN
    check("bubble_cnt", bubble_cnt, exp_bubble);
    check("retire_cnt", retire_cnt, exp_retire);
`endif
  endtask

  task automatic advance_model();
    if (!resetn) begin
      model_reset();
    end else begin
`ifdef CTRL_PIPE_STATS_EN
      if (stall || flush) exp_bubble = exp_bubble + 1;
      if (q[2].valid) exp_retire = exp_retire + 1;
`endif
      q.push_front((stall || flush) ? nop_b() : issued_b());
      void'(q.pop_back());
    end
  endtask

  // Compare on the falling edge, then advance across the rising edge; returns at posedge+1.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    advance_model();
    #1;
  endtask

  task automatic set_nop();
    resetn = 1; d_valid = 0; d_wreg = 0; d_mem2reg = 0; d_wmem = 0;
    d_aluc = '0; d_aluimm = 0; d_shift = 0; d_jal = 0; d_rn = '0;
    d_rs = '0; d_rt = '0; d_use_rs = 0; d_use_rt = 0; stall = 0; flush = 0;
  endtask

  initial begin
    set_nop();
    resetn = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // Reset discards a full pipe
    set_nop();
    d_valid = 1; d_wreg = 1; d_rn = 5;
    repeat (3) cycle();
    resetn = 0;
    cycle();
    check("rst_e_valid", e_valid, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_w_valid", w_valid, 0);
    check("rst_w_wreg", w_wreg, 0);
    check("rst_m_rn", m_rn, 0);
    check("rst_e_rn", e_rn, 0);

    // Latency through the three stages
    set_nop();
    d_valid = 1; d_wreg = 1; d_rn = 9; d_aluc = 4'b0010;
    cycle();
    check("lat_e_rn", e_rn, 9);
    check("lat_e_aluc", e_aluc, 2);
    set_nop();
    cycle();
    check("lat_m_rn", m_rn, 9);
    cycle();
    check("lat_w_wreg", w_wreg, 1);
    check("lat_w_rn", w_rn, 9);
    cycle();
    check("lat_w_wreg_after", w_wreg, 0);

    // r0 destination never writes
    d_valid = 1; d_wreg = 1; d_rn = 0;
    cycle();
    check("r0_e_wreg", e_wreg, 0);
    set_nop();
    repeat (3) cycle();

    // Load-use hazard, then stall turns EX into a bubble
    d_valid = 1; d_wreg = 1; d_mem2reg = 1; d_rn = 7;
    cycle();
    set_nop();
    d_valid = 1; d_rt = 7; d_use_rt = 1; stall = 1;
    #1;
    check("lu_hit", load_use, 1);
    cycle();
    check("lu_stall_e_valid", e_valid, 0);
    check("lu_stall_m_rn", m_rn, 7);
    check("lu_cleared", load_use, 0);
    stall = 0;
    cycle();

    // Stall and flush together insert exactly one bubble
    set_nop();
    d_valid = 1; d_wmem = 1; stall = 1; flush = 1;
    cycle();
    check("sf_e_wmem", e_wmem, 0);
    check("sf_e_valid", e_valid, 0);
    set_nop();
    d_valid = 1; d_wreg = 1; d_rn = 3;
    cycle();
    check("sf_m_wmem", m_wmem, 0);
    check("sf_e_valid_next", e_valid, 1);
    check("sf_m_valid", m_valid, 0);
    set_nop();
    repeat (3) cycle();

`ifdef CTRL_PIPE_STATS_EN
    // 10 captured instructions with 3 stall cycles interleaved
    resetn = 0;
    cycle();
    for (int i = 0; i < 13; i++) begin
      set_nop();
      d_valid = 1; d_wreg = 1; d_rn = RW'(i + 1);
      stall = (i == 2 || i == 5 || i == 8);
      cycle();
    end
    set_nop();
    repeat (4) cycle();
    check("stats_retire", retire_cnt, 10);
    check("stats_bubble", bubble_cnt, 3);
`endif

    // Randomized traffic; small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      resetn    = ($urandom_range(0, 49) != 0);
      d_valid   = ($urandom_range(0, 3) != 0);
      d_wreg    = 1'($urandom);
      d_mem2reg = 1'($urandom);
      d_wmem    = 1'($urandom);
      d_aluc    = ALUC_W'($urandom);
      d_aluimm  = 1'($urandom);
      d_shift   = 1'($urandom);
      d_jal     = 1'($urandom);
      d_rn      = RW'($urandom_range(0, 7));
      d_rs      = RW'($urandom_range(0, 7));
      d_rt      = RW'($urandom_range(0, 7));
      d_use_rs  = 1'($urandom);
      d_use_rt  = 1'($urandom);
      stall     = ($urandom_range(0, 7) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      cycle();
    end
    set_nop();
    repeat (4) cycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Downstream consumer of the ID-stage decoder bundle (wreg, mem2reg, wmem, aluc, aluimm, shift, jal, dest reg).
- Carries the bundle through the EX, MEM and WB pipeline registers and inserts bubbles on stall or flush.
- Returns per-stage destination/write info to the decoder for forwarding and load-use decisions.
- Closes the loop opposite the decoder: the decoder issues control, this block retires it and reports hazards back.

Parameters:
- RW, 5, register-number width.
- ALUC_W, 4, ALU control width.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- d_valid  in  1  ID stage holds a real instruction.
- d_wreg  in  1  decoded register write enable.
- d_mem2reg  in  1  decoded load (result from memory).
- d_wmem  in  1  decoded store.
- d_aluc  in  ALUC_W  decoded ALU op.
- d_aluimm  in  1  decoded immediate operand select.
- d_shift  in  1  decoded shift-amount select.
- d_jal  in  1  decoded link write.
- d_rn  in  RW  resolved destination register (rt/rd/31 already selected).
- d_rs, d_rt  in  RW  ID source register numbers.
- d_use_rs, d_use_rt  in  1  ID instruction reads rs / rt.
- stall  in  1  hold ID, bubble into EX.
- flush  in  1  squash ID instruction, bubble into EX.
- e_wreg, e_m2reg, e_wmem, e_aluimm, e_shift, e_jal  out  1  EX-stage controls.
- e_aluc  out  ALUC_W  EX-stage ALU op.
- e_rn  out  RW  EX-stage destination.
- m_wreg, m_m2reg, m_wmem  out  1  MEM-stage controls.
- m_rn  out  RW  MEM-stage destination.
- w_wreg, w_m2reg  out  1  WB-stage controls.
- w_rn  out  RW  WB-stage destination.
- e_valid, m_valid, w_valid  out  1  stage holds a real instruction.
- load_use  out  1  combinational load-use hazard request to the decoder.

Behaviour:
- Reset: on a clk edge with resetn=0, every stage register clears to 0. All e_/m_/w_ outputs and valid bits read 0 (NOP) from the next cycle. Reset overrides stall/flush. Reset mid-pipeline discards all in-flight instructions; no partial writes survive.
- Capture qualification into EX:
  - wreg_q = d_wreg & d_valid & (d_rn != 0).
  - wmem_q = d_wmem & d_valid.
  - Other fields copied as-is.
- Per-edge advance, resetn=1:
  - if stall|flush: EX <= all-zero bubble (valid=0, wreg=0, wmem=0, rn=0); else EX <= qualified D bundle with valid=d_valid.
  - MEM <= EX fields {valid, wreg, m2reg, wmem, rn} unconditionally.
  - WB <= MEM fields {valid, wreg, m2reg, rn} unconditionally.
- stall and flush together: a single bubble, same as either alone. The block never holds EX/MEM/WB; only ID is held, externally.
- Latency: a D bundle appears at e_* 1 cycle after capture, m_* after 2, w_* after 3.
- load_use = e_valid & e_m2reg & e_wreg & ((d_use_rs & d_rs==e_rn) | (d_use_rt & d_rt==e_rn)).
  - e_rn==0 never asserts, since wreg is already cleared.
  - Purely combinational, no register delay.
- No valid/ready handshake; the pipeline advances every cycle.

Optional Feature:
- Macro CTRL_PIPE_STATS_EN.
- When defined:
  - Adds outputs bubble_cnt[31:0] and retire_cnt[31:0], both cleared by reset.
  - bubble_cnt increments on each edge where stall|flush inserts a bubble.
  - retire_cnt increments on each edge where w_valid=1.
  - Both counters wrap from 0xFFFFFFFF to 0.
- When undefined: neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
- Reset flush: fill the pipe with d_valid=1, d_wreg=1, d_rn=5 for 3 cycles, then resetn=0 for one edge -> next cycle all e_/m_/w_ outputs = 0, valid bits = 0.
- Latency: one instruction d_wreg=1, d_rn=9, d_aluc=4'b0010, then NOPs -> e_rn=9/e_aluc=2 at cycle+1, m_rn=9 at +2, w_wreg=1/w_rn=9 at +3, then 0.
- r0 suppression: d_wreg=1, d_rn=0 -> e_wreg=0, m_wreg=0, w_wreg=0 throughout.
- Load-use:
  - EX holds a load (e_m2reg=1, e_wreg=1, e_rn=7) with d_rt=7, d_use_rt=1 -> load_use=1 the same cycle.
  - Drive stall=1 -> next cycle e_valid=0 and the load is at m_rn=7; load_use=0.
- Stall+flush together with d_wmem=1 -> EX bubble, e_wmem=0, m_wmem=0 next cycle; only one bubble inserted.
- With CTRL_PIPE_STATS_EN: 10 valid instructions plus 3 stalls -> after drain, retire_cnt=10 and bubble_cnt=3.
